// File: rtl/if_id_fetch_queue.sv
// IF->ID fetch queue: buffers fetched instruction/next_pc pairs for decode and
// drives the branch/jump redirect pulses back to IF, flushing wrong-path work.
module if_id_fetch_queue #(
   parameter int unsigned PC_WIDTH = 32,
   parameter int unsigned DEPTH    = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        if_valid,
   input  logic [31:0]                 instruction,
   input  logic [PC_WIDTH-1:0]         next_pc,
   output logic                        if_stall,
   output logic                        id_valid,
   output logic [31:0]                 id_instruction,
   output logic [PC_WIDTH-1:0]         id_next_pc,
   input  logic                        id_ready,
   input  logic                        id_is_jump,
   input  logic [PC_WIDTH-1:0]         id_jump_addr,
   input  logic                        ex_branch_taken,
   input  logic [PC_WIDTH-1:0]         ex_branch_addr,
   output logic [PC_WIDTH-1:0]         branch_addr,
   output logic [PC_WIDTH-1:0]         jump_addr,
   output logic                        is_branch,
   output logic                        is_jump,
   output logic [$clog2(DEPTH):0]      count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]         mem_instr [DEPTH];
   logic [PC_WIDTH-1:0] mem_pc    [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;

   logic shadow;
   logic jump_take;
   logic flush;
   logic push;
   logic pop;

   // Status, head presentation and redirect qualification.
   always_comb begin
      if_stall       = (count == CW'(DEPTH));
      id_valid       = (count != '0);
      id_instruction = id_valid ? mem_instr[rd_ptr] : 32'h0;
      id_next_pc     = id_valid ? mem_pc[rd_ptr] : '0;
      shadow         = is_branch | is_jump;
      // The older EX branch wins over a jump decoded from the head.
      jump_take      = id_valid & id_ready & id_is_jump & ~ex_branch_taken;
      flush          = ex_branch_taken | jump_take;
      push           = if_valid & ~if_stall & ~shadow & ~flush;
      pop            = id_valid & id_ready & ~ex_branch_taken;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         is_branch   <= 1'b0;
         is_jump     <= 1'b0;
         branch_addr <= '0;
         jump_addr   <= '0;
      end else begin
         is_branch <= ex_branch_taken;
         is_jump   <= jump_take;
         if (ex_branch_taken) branch_addr <= ex_branch_addr;
         if (jump_take)       jump_addr   <= id_jump_addr;
         // A jump pops its own entry; clearing everything covers that too.
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Payload storage needs no reset; empty entries are masked at the head.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= instruction;
         mem_pc[wr_ptr]    <= next_pc;
      end
   end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed, table-driven bench for if_id_fetch_queue (DEPTH=2, PC_WIDTH=32).
module tb_if_id_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] instruction;
   logic [31:0] next_pc;
   logic        if_stall;
   logic        id_valid;
   logic [31:0] id_instruction;
   logic [31:0] id_next_pc;
   logic        id_ready;
   logic        id_is_jump;
   logic [31:0] id_jump_addr;
   logic        ex_branch_taken;
   logic [31:0] ex_branch_addr;
   logic [31:0] branch_addr;
   logic [31:0] jump_addr;
   logic        is_branch;
   logic        is_jump;
   logic [1:0]  count;

   if_id_fetch_queue #(.PC_WIDTH(32), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction),
      .next_pc(next_pc), .if_stall(if_stall), .id_valid(id_valid),
      .id_instruction(id_instruction), .id_next_pc(id_next_pc),
      .id_ready(id_ready), .id_is_jump(id_is_jump), .id_jump_addr(id_jump_addr),
      .ex_branch_taken(ex_branch_taken), .ex_branch_addr(ex_branch_addr),
      .branch_addr(branch_addr), .jump_addr(jump_addr),
      .is_branch(is_branch), .is_jump(is_jump), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        if_valid;
      logic [31:0] instr;
      logic [31:0] npc;
      logic        ready;
      logic        isj;
      logic [31:0] jaddr;
      logic        ex;
      logic [31:0] exaddr;
      logic [1:0]  e_count;
      logic        e_stall;
      logic [31:0] e_instr;
      logic [31:0] e_npc;
      logic        e_isb;
      logic        e_isj;
      logic [31:0] e_baddr;
      logic [31:0] e_jaddr;
   } vec_t;

   vec_t vq[$];
   int   checks   = 0;
   int   failures = 0;
   int   cur      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", cur, name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst             = v.rst;
      if_valid        = v.if_valid;
      instruction     = v.instr;
      next_pc         = v.npc;
      id_ready        = v.ready;
      id_is_jump      = v.isj;
      id_jump_addr    = v.jaddr;
      ex_branch_taken = v.ex;
      ex_branch_addr  = v.exaddr;
   endtask

   initial begin
      //           rst  ifv   instr         npc     rdy  isj  jaddr   ex   exaddr  | cnt  stall e_instr       e_npc  isb  isj  baddr    jaddr
      vq.push_back('{1'b1,1'b0,32'h0,        32'h0,  1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd0,1'b0,32'h0,        32'h0, 1'b0,1'b0,32'h0,   32'h0});
      vq.push_back('{1'b0,1'b0,32'h0,        32'h0,  1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd0,1'b0,32'h0,        32'h0, 1'b0,1'b0,32'h0,   32'h0});
      vq.push_back('{1'b0,1'b0,32'h0,        32'h0,  1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd0,1'b0,32'h0,        32'h0, 1'b0,1'b0,32'h0,   32'h0});
      vq.push_back('{1'b0,1'b0,32'h0,        32'h0,  1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd0,1'b0,32'h0,        32'h0, 1'b0,1'b0,32'h0,   32'h0});
      // fill to full, refused push, pop with refused push, retry
      vq.push_back('{1'b0,1'b1,32'h11111111,32'h4,  1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd1,1'b0,32'h11111111,32'h4, 1'b0,1'b0,32'h0,   32'h0});
      vq.push_back('{1'b0,1'b1,32'h22222222,32'h8,  1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd2,1'b1,32'h11111111,32'h4, 1'b0,1'b0,32'h0,   32'h0});
      vq.push_back('{1'b0,1'b1,32'h33333333,32'hc,  1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd2,1'b1,32'h11111111,32'h4, 1'b0,1'b0,32'h0,   32'h0});
      vq.push_back('{1'b0,1'b1,32'h33333333,32'hc,  1'b1,1'b0,32'h0,  1'b0,32'h0,   2'd1,1'b0,32'h22222222,32'h8, 1'b0,1'b0,32'h0,   32'h0});
      vq.push_back('{1'b0,1'b1,32'h33333333,32'hc,  1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd2,1'b1,32'h22222222,32'h8, 1'b0,1'b0,32'h0,   32'h0});
      vq.push_back('{1'b0,1'b0,32'h0,        32'h0,  1'b1,1'b0,32'h0,  1'b0,32'h0,   2'd1,1'b0,32'h33333333,32'hc, 1'b0,1'b0,32'h0,   32'h0});
      // simultaneous push/pop, then full again
      vq.push_back('{1'b0,1'b1,32'h44444444,32'h10, 1'b1,1'b0,32'h0,  1'b0,32'h0,   2'd1,1'b0,32'h44444444,32'h10,1'b0,1'b0,32'h0,   32'h0});
      vq.push_back('{1'b0,1'b1,32'h55555555,32'h14, 1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd2,1'b1,32'h44444444,32'h10,1'b0,1'b0,32'h0,   32'h0});
      // branch flush, shadow-cycle fetch dropped, then accepted
      vq.push_back('{1'b0,1'b1,32'h66666666,32'h18, 1'b0,1'b0,32'h0,  1'b1,32'h40,  2'd0,1'b0,32'h0,        32'h0, 1'b1,1'b0,32'h40,  32'h0});
      vq.push_back('{1'b0,1'b1,32'h66666666,32'h18, 1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd0,1'b0,32'h0,        32'h0, 1'b0,1'b0,32'h40,  32'h0});
      vq.push_back('{1'b0,1'b1,32'h66666666,32'h18, 1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd1,1'b0,32'h66666666,32'h18,1'b0,1'b0,32'h40,  32'h0});
      // jump at head with one trailing entry
      vq.push_back('{1'b0,1'b1,32'h77777777,32'h1c, 1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd2,1'b1,32'h66666666,32'h18,1'b0,1'b0,32'h40,  32'h0});
      vq.push_back('{1'b0,1'b1,32'h88888888,32'h20, 1'b1,1'b1,32'h80, 1'b0,32'h0,   2'd0,1'b0,32'h0,        32'h0, 1'b0,1'b1,32'h40,  32'h80});
      vq.push_back('{1'b0,1'b0,32'h0,        32'h0,  1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd0,1'b0,32'h0,        32'h0, 1'b0,1'b0,32'h40,  32'h80});
      // branch and jump together: branch wins, jump_addr holds
      vq.push_back('{1'b0,1'b1,32'h99999999,32'h24, 1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd1,1'b0,32'h99999999,32'h24,1'b0,1'b0,32'h40,  32'h80});
      vq.push_back('{1'b0,1'b0,32'h0,        32'h0,  1'b1,1'b1,32'h180,1'b1,32'h100, 2'd0,1'b0,32'h0,        32'h0, 1'b1,1'b0,32'h100, 32'h80});
      // back-to-back branches, then reset during the second pulse's event
      vq.push_back('{1'b0,1'b0,32'h0,        32'h0,  1'b0,1'b0,32'h0,  1'b1,32'h40,  2'd0,1'b0,32'h0,        32'h0, 1'b1,1'b0,32'h40,  32'h80});
      vq.push_back('{1'b0,1'b0,32'h0,        32'h0,  1'b0,1'b0,32'h0,  1'b1,32'h60,  2'd0,1'b0,32'h0,        32'h0, 1'b1,1'b0,32'h60,  32'h80});
      vq.push_back('{1'b1,1'b0,32'h0,        32'h0,  1'b0,1'b0,32'h0,  1'b1,32'h99,  2'd0,1'b0,32'h0,        32'h0, 1'b0,1'b0,32'h0,   32'h0});
      vq.push_back('{1'b0,1'b0,32'h0,        32'h0,  1'b0,1'b0,32'h0,  1'b0,32'h0,   2'd0,1'b0,32'h0,        32'h0, 1'b0,1'b0,32'h0,   32'h0});
      // pop on empty queue is ignored
      vq.push_back('{1'b0,1'b0,32'h0,        32'h0,  1'b1,1'b0,32'h0,  1'b0,32'h0,   2'd0,1'b0,32'h0,        32'h0, 1'b0,1'b0,32'h0,   32'h0});
      vq.push_back('{1'b0,1'b1,32'haaaaaaaa,32'h28, 1'b1,1'b0,32'h0,  1'b0,32'h0,   2'd1,1'b0,32'haaaaaaaa,32'h28,1'b0,1'b0,32'h0,   32'h0});

      foreach (vq[i]) begin
         cur = i;
         drive(vq[i]);
         @(posedge clk);
         #1;
         chk("count",          32'(count),        32'(vq[i].e_count));
         chk("if_stall",       32'(if_stall),     32'(vq[i].e_stall));
         chk("id_valid",       32'(id_valid),     32'(vq[i].e_count != 2'd0));
         chk("id_instruction", id_instruction,    vq[i].e_instr);
         chk("id_next_pc",     id_next_pc,        vq[i].e_npc);
         chk("is_branch",      32'(is_branch),    32'(vq[i].e_isb));
         chk("is_jump",        32'(is_jump),      32'(vq[i].e_isj));
         chk("branch_addr",    branch_addr,       vq[i].e_baddr);
         chk("jump_addr",      jump_addr,         vq[i].e_jaddr);
      end

      // No fall-through: drain, then a new fetch is invisible until the edge.
      cur = 100;
      rst = 1'b0; if_valid = 1'b0; id_ready = 1'b1; id_is_jump = 1'b0; ex_branch_taken = 1'b0;
      @(posedge clk);
      #1;
      chk("drain_count", 32'(count), 32'd0);
      id_ready = 1'b0; if_valid = 1'b1; instruction = 32'hbbbbbbbb; next_pc = 32'h2c;
      #1;
      chk("nofall_valid", 32'(id_valid), 32'd0);
      chk("nofall_instr", id_instruction, 32'h0);
      @(posedge clk);
      #1;
      if_valid = 1'b0;
      chk("latency_valid", 32'(id_valid), 32'd1);
      chk("latency_instr", id_instruction, 32'hbbbbbbbb);
      chk("latency_npc", id_next_pc, 32'h2c);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
